seq_detector_prog: RTL
======================

Name: seq_detector_prog

Overview:
- Parametrised, run-time programmable serial pattern detector. Successor to the fixed 4-bit "1011" Moore detector.
- Watches a qualified 1-bit stream and pulses a registered detect flag when the last cfg_len accepted bits equal a programmable pattern.
- Supports overlapping and non-overlapping match modes, and keeps a saturating detection counter.
- Sits between the serial front-end and the event/status logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2).
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- CNT_W, 16, width of the detection counter.
- DEF_PATTERN, 'b1011, reset pattern; bit 0 is the last bit received.
- DEF_LEN, 4, reset pattern length.
- DEF_OVERLAP, 0, reset mode (0 = non-overlapping).

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- seq_valid  in  1  seq_in is sampled on this edge
- seq_in  in  1  serial data bit
- cfg_we  in  1  load cfg_* on this edge
- cfg_pattern  in  MAX_LEN  pattern; bits [cfg_len-1:0] are used; bit cfg_len-1 is the first bit received
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping match mode
- count_clr  in  1  clear detect_count
- detect_out  out  1  one-cycle registered match pulse
- detect_count  out  CNT_W  saturating number of matches
- cfg_err  out  1  one-cycle pulse: illegal config write rejected
- armed  out  1  enough bits accumulated to allow a match

Behaviour:
- Synchronous reset: one clock, synchronous and active-high, as already decided. On reset:
  - hist = 0, fill = 0, state = FILL.
  - detect_out, detect_count, cfg_err and armed = 0.
  - Active config = DEF_PATTERN / DEF_LEN / DEF_OVERLAP.
  - Reset has priority over all other inputs.
- Accepted bit: seq_valid = 1 at a posedge. Then:
  - hist <= {hist[MAX_LEN-2:0], seq_in}.
  - fill <= min(fill+1, MAX_LEN).
- seq_valid = 0: hist, fill and state hold; detect_out = 0 next cycle.
- Match is evaluated on the post-shift history:
  - Condition: (hist_next & mask) == (pattern & mask) AND fill_next ≥ len, with mask = low len bits set.
- Latency:
  - detect_out is registered. It is high for exactly the one cycle following the edge that accepted the final pattern bit, otherwise 0.
  - Back-to-back pulses are legal in overlap mode, e.g. pattern "11" on a stream of 1s.
- FSM:
  - FILL: fill < len; armed = 0.
  - ARMED: fill ≥ len; armed = 1.
  - FILL→ARMED when fill_next ≥ len.
  - ARMED→FILL on a match in non-overlap mode only. fill <= 0 on that edge, so hist bits are consumed and the next match needs len fresh bits.
  - In overlap mode fill is never cleared by a match.
  - Any accepted cfg write → FILL, with fill = 0 and hist = 0.
- Config write (cfg_we = 1):
  - Legal when 2 ≤ cfg_len ≤ MAX_LEN. Pattern, len and overlap are loaded at that edge.
  - A seq_valid bit on the same edge is discarded, and detect_out = 0 next cycle.
  - Illegal cfg_len (<2 or >MAX_LEN): write ignored, config, hist and fill unchanged, the seq_valid bit is processed normally, and cfg_err = 1 for one cycle.
- detect_count:
  - Increments by 1 on each match edge and saturates at 2^CNT_W-1 (no wrap).
  - count_clr clears it to 0.
  - count_clr and a match on the same edge → count = 1.
- Pattern bits above len are don't-care.
- hist is MAX_LEN wide regardless of len.

Test Plan:
- Default config, valid stream 1,0,1,1,0,1,1 on consecutive cycles → detect_out high only in the cycle after bit 4; detect_count = 1.
- cfg_overlap = 1, len = 4, pattern 1011, same stream → pulses after bits 4 and 7; detect_count = 2.
- Default config, stream 1,0,1,1 with seq_valid low for 3 cycles between bits 2 and 3 → single pulse one cycle after the 4th accepted bit; no pulse while seq_valid = 0.
- cfg_we with len = 8, pattern 0xA5, then stream 1,0,1,0,0,1,0,1 → armed rises after bit 8, detect pulse after bit 8; a cfg_we with len = 1 → cfg_err pulse, config unchanged.
- CNT_W = 2, overlap, pattern "11", ten consecutive 1s → detect_count saturates at 3; count_clr together with a match → count = 1.
- reset asserted after bits 1,0,1 of 1011, then 1 → no detect; count, fill and armed = 0 and config returns to defaults.

Source files
------------

// File: rtl/seq_detector_prog_if.sv
// Bus bundle for the programmable serial pattern detector: stream input,
// configuration write port and the detect/status outputs.
interface seq_detector_prog_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 16
);
   logic               seq_valid;
   logic               seq_in;
   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               count_clr;
   logic               detect_out;
   logic [CNT_W-1:0]   detect_count;
   logic               cfg_err;
   logic               armed;

   modport master (
      output seq_valid, seq_in, cfg_we, cfg_pattern, cfg_len, cfg_overlap, count_clr,
      input  detect_out, detect_count, cfg_err, armed
   );

   modport slave (
      input  seq_valid, seq_in, cfg_we, cfg_pattern, cfg_len, cfg_overlap, count_clr,
      output detect_out, detect_count, cfg_err, armed
   );
endinterface

// File: rtl/seq_detector_prog.sv
// Run-time programmable serial pattern detector with overlap/non-overlap
// match modes, a registered detect pulse and a saturating match counter.
module seq_detector_prog #(
   parameter int                      MAX_LEN     = 8,
   parameter int                      LEN_W       = $clog2(MAX_LEN + 1),
   parameter int                      CNT_W       = 16,
   parameter logic [MAX_LEN-1:0]      DEF_PATTERN = MAX_LEN'(4'b1011),
   parameter logic [LEN_W-1:0]        DEF_LEN     = LEN_W'(4),
   parameter logic                    DEF_OVERLAP = 1'b0
) (
   input logic                clk,
   input logic                reset,
   seq_detector_prog_if.slave bus
);

   typedef enum logic {S_FILL, S_ARMED} state_t;

   localparam logic [LEN_W-1:0] FULL    = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(2);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             state;
   logic [MAX_LEN-1:0] pattern_q;
   logic [LEN_W-1:0]   len_q;
   logic               overlap_q;
   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   fill;
   logic               detect_q;
   logic               err_q;
   logic [CNT_W-1:0]   count_q;

   logic [MAX_LEN-1:0] hist_next;
   logic [LEN_W-1:0]   fill_next;
   logic [MAX_LEN-1:0] mask;
   logic               cfg_ok;
   logic               cfg_load;
   logic               match;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      mask      = '0;
      hist_next = {hist[MAX_LEN-2:0], bus.seq_in};
      fill_next = (fill == FULL) ? FULL : fill + LEN_W'(1);
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len_q));
      end
      cfg_ok   = (bus.cfg_len >= MIN_LEN) && (bus.cfg_len <= FULL);
      cfg_load = bus.cfg_we && cfg_ok;
      // A legal config write on the same edge discards the incoming bit.
      match    = bus.seq_valid && !cfg_load
                 && (((hist_next ^ pattern_q) & mask) == '0)
                 && (fill_next >= len_q);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FILL;
         pattern_q <= DEF_PATTERN;
         len_q     <= DEF_LEN;
         overlap_q <= DEF_OVERLAP;
         hist      <= '0;
         fill      <= '0;
         detect_q  <= 1'b0;
         err_q     <= 1'b0;
         count_q   <= '0;
      end else begin
         detect_q <= match;
         err_q    <= bus.cfg_we && !cfg_ok;

         if (bus.count_clr) begin
            count_q <= match ? CNT_W'(1) : '0;
         end else if (match && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
         end

         if (cfg_load) begin
            pattern_q <= bus.cfg_pattern;
            len_q     <= bus.cfg_len;
            overlap_q <= bus.cfg_overlap;
            hist      <= '0;
            fill      <= '0;
            state     <= S_FILL;
         end else if (bus.seq_valid) begin
            hist <= hist_next;
            // Non-overlap matches consume the history; the next match needs len fresh bits.
            if (match && !overlap_q) begin
               fill  <= '0;
               state <= S_FILL;
            end else begin
               fill  <= fill_next;
               state <= (fill_next >= len_q) ? S_ARMED : S_FILL;
            end
         end
      end
   end

   assign bus.detect_out   = detect_q;
   assign bus.detect_count = count_q;
   assign bus.cfg_err      = err_q;
   assign bus.armed        = (state == S_ARMED);

endmodule
